// File: rtl/cpu_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module : cpu_hazard_ctl
// Pipeline interlock: register hazards, load waits and memory-wait freezes.
// Rev    : 1.0
// ============================================================================
module cpu_hazard_ctl #(
  parameter int REGISTER_BITS = 8,
  parameter int DEPTH         = 4,
  parameter int MEM_SLOT      = 3,
  parameter int COUNT_BITS    = 16
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic [REGISTER_BITS-1:0] regA_sel,
  input  logic [REGISTER_BITS-1:0] regB_sel,
  input  logic                     issue_valid,
  input  logic                     issue_writes,
  input  logic [REGISTER_BITS-1:0] issue_dest,
  input  logic                     issue_is_load,
  input  logic                     load_done,
  input  logic                     mem_wait,
  input  logic                     flush,
  output logic                     stall,
  output logic                     bubble,
  output logic                     freeze,
  output logic                     load_wait,
  output logic [COUNT_BITS-1:0]    stall_count
);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_t;

  state_t                   r_state;
  logic [COUNT_BITS-1:0]    r_count;
  logic [DEPTH:1]           r_valid;
  logic [DEPTH:1]           r_load;
  logic [REGISTER_BITS-1:0] r_tag [1:DEPTH];

  logic [DEPTH:1]           w_match;
  logic                     w_hazard;
  logic                     w_load_enter;
  logic                     w_freeze;
  logic                     w_stall;
  logic                     w_new_valid;
  logic                     w_new_load;
  logic [REGISTER_BITS-1:0] w_new_tag;

  // Writeback slot is included: the register file only updates at the cycle end.
  generate
    for (genvar g = 1; g <= DEPTH; g++) begin : g_match
      assign w_match[g] = r_valid[g] &&
                          (((regA_sel != '0) && (regA_sel == r_tag[g])) ||
                           ((regB_sel != '0) && (regB_sel == r_tag[g])));
    end
  endgenerate

  assign w_hazard     = issue_valid && (|w_match);
  assign w_load_enter = (r_state == ST_IDLE) && r_load[MEM_SLOT] && !load_done;
  assign w_freeze     = mem_wait ||
                        ((r_state == ST_LOAD_WAIT) && !load_done) ||
                        w_load_enter;
  assign w_stall      = w_freeze || w_hazard;

  assign stall        = w_stall;
  assign bubble       = w_hazard && !w_freeze;
  assign freeze       = w_freeze;
  assign load_wait    = (r_state == ST_LOAD_WAIT);
  assign stall_count  = r_count;

  assign w_new_valid  = issue_valid && issue_writes && (issue_dest != '0) &&
                        !w_hazard && !flush;
  assign w_new_load   = issue_valid && issue_is_load && !w_hazard && !flush;
  assign w_new_tag    = w_hazard ? '0 : issue_dest;

  // Flush is applied after the shift, so it wins over the newly loaded slots.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_valid <= '0;
      r_load  <= '0;
      for (int i = 1; i <= DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      if (!w_freeze) begin
        for (int i = DEPTH; i >= 2; i--) begin
          r_valid[i] <= r_valid[i-1];
          r_load[i]  <= r_load[i-1];
          r_tag[i]   <= r_tag[i-1];
        end
        r_valid[1] <= w_new_valid;
        r_load[1]  <= w_new_load;
        r_tag[1]   <= w_new_tag;
      end
      if (flush) begin
        for (int i = 1; i < MEM_SLOT; i++) begin
          r_valid[i] <= 1'b0;
          r_load[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE:      if (w_load_enter) r_state <= ST_LOAD_WAIT;
        ST_LOAD_WAIT: if (load_done)    r_state <= ST_IDLE;
        default:                        r_state <= ST_IDLE;
      endcase
      if (w_stall && (r_count != '1)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_hazard_ctl
// Vector table plus hand sequences for saturation and reset during a load wait.
// Rev    : 1.0
// ============================================================================
module tb_cpu_hazard_ctl;

  localparam logic [3:0] c_NONE = 4'b0000; // {stall, bubble, freeze, load_wait}
  localparam logic [3:0] c_SB   = 4'b1100;
  localparam logic [3:0] c_FZ   = 4'b1010;
  localparam logic [3:0] c_FZL  = 4'b1011;
  localparam logic [3:0] c_LW   = 4'b0001;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic [7:0]  regA_sel, regB_sel, issue_dest;
  logic        issue_valid, issue_writes, issue_is_load, load_done, mem_wait, flush;
  logic        stall, bubble, freeze, load_wait;
  logic [15:0] stall_count;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       iv;
    logic       iw;
    logic [7:0] d;
    logic       il;
    logic       ld;
    logic       mw;
    logic       fl;
    logic [3:0] want;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   model_cnt = 0;

  cpu_hazard_ctl #(
    .REGISTER_BITS(8), .DEPTH(4), .MEM_SLOT(3), .COUNT_BITS(16)
  ) dut (
    .CLK(CLK), .RSTb(RSTb),
    .regA_sel(regA_sel), .regB_sel(regB_sel),
    .issue_valid(issue_valid), .issue_writes(issue_writes),
    .issue_dest(issue_dest), .issue_is_load(issue_is_load),
    .load_done(load_done), .mem_wait(mem_wait), .flush(flush),
    .stall(stall), .bubble(bubble), .freeze(freeze), .load_wait(load_wait),
    .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic iv, input logic iw, input logic [7:0] d,
                              input logic il, input logic ld, input logic mw,
                              input logic fl, input logic [3:0] want);
    vec_t v;
    v.a = a; v.b = b; v.iv = iv; v.iw = iw; v.d = d;
    v.il = il; v.ld = ld; v.mw = mw; v.fl = fl; v.want = want;
    return v;
  endfunction

  task automatic clear_inputs();
    regA_sel = '0; regB_sel = '0; issue_dest = '0;
    issue_valid = 1'b0; issue_writes = 1'b0; issue_is_load = 1'b0;
    load_done = 1'b0; mem_wait = 1'b0; flush = 1'b0;
  endtask

  task automatic check_out(input int idx);
    vec_t e;
    e = sb_q.pop_front();
    n_vec++;
    if ({stall, bubble, freeze, load_wait} !== e.want) begin
      n_err++;
      $display("FAIL vec %0d flags{stall,bubble,freeze,load_wait}: got %b want %b",
               idx, {stall, bubble, freeze, load_wait}, e.want);
    end
    n_vec++;
    if (stall_count !== model_cnt[15:0]) begin
      n_err++;
      $display("FAIL vec %0d stall_count: got %0d want %0d", idx, stall_count, model_cnt);
    end
    if (e.want[3] && model_cnt < 65535) model_cnt++;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge CLK);
    #1;
    regA_sel = v.a; regB_sel = v.b; issue_valid = v.iv; issue_writes = v.iw;
    issue_dest = v.d; issue_is_load = v.il; load_done = v.ld;
    mem_wait = v.mw; flush = v.fl;
    sb_q.push_back(v);
    @(negedge CLK);
    check_out(idx);
  endtask

  task automatic do_reset();
    RSTb = 1'b0;
    clear_inputs();
    #2;
    n_vec++;
    if ({stall, bubble, freeze, load_wait} !== 4'b0000 || stall_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset: flags=%b count=%0d want flags=0000 count=0",
               {stall, bubble, freeze, load_wait}, stall_count);
    end
    @(negedge CLK);
    RSTb = 1'b1;
    model_cnt = 0;
    sb_q.delete();
  endtask

  initial begin
    clear_inputs();
    // RAW hazard on r5 through every tracked slot, then regB hazard on r9
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd5, 0, 0, 0, 0, c_NONE));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(8'd5, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_SB));
    vecs.push_back(mk(8'd5, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd9, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd9, 1, 0, 8'd0, 0, 0, 0, 0, c_SB));
    // r0 is never tracked; non-writing issues leave invalid tags
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 1, 0, 8'd6, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd6, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    // issue_valid gates the hazard
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd2, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd2, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(8'd2, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_SB));
    vecs.push_back(mk(8'd2, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    // load r7 waits three cycles in the memory slot
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd7, 1, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_FZ));
    vecs.push_back(mk(8'd7, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_FZL));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_FZL));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 1, 0, 0, c_LW));
    vecs.push_back(mk(8'd7, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_SB));
    vecs.push_back(mk(8'd7, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    // load data arrives the cycle the load reaches the memory slot
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd7, 1, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 1, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    // load to r0 is untracked but still waits for memory
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd0, 1, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_FZ));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 1, 0, 0, c_LW));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    // flush during a freeze drops r3 (slot 1) but keeps r4 (memory slot)
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd4, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd3, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 1, 1, c_FZ));
    vecs.push_back(mk(8'd3, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd4, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_SB));
    vecs.push_back(mk(8'd4, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_NONE));
    // plain flush suppresses the slot-0 write of r11 and drops r3
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd3, 0, 0, 0, 0, c_NONE));
    vecs.push_back(mk(8'd0, 8'd0, 1, 1, 8'd11, 0, 0, 0, 1, c_NONE));
    vecs.push_back(mk(8'd3, 8'd11, 1, 0, 8'd0, 0, 0, 0, 0, c_NONE));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // stall_count saturation under a long memory wait
    do_reset();
    @(posedge CLK);
    #1 mem_wait = 1'b1;
    repeat (65534) @(posedge CLK);
    @(negedge CLK);
    n_vec++;
    if (stall_count !== 16'd65534) begin
      n_err++;
      $display("FAIL sat_pre: got %0d want 65534", stall_count);
    end
    @(negedge CLK);
    n_vec++;
    if (stall_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_hit: got %0d want 65535", stall_count);
    end
    repeat (4) @(negedge CLK);
    n_vec++;
    if (stall_count !== 16'hFFFF || stall !== 1'b1 || freeze !== 1'b1) begin
      n_err++;
      $display("FAIL sat_hold: got count=%0d stall=%b freeze=%b want 65535/1/1",
               stall_count, stall, freeze);
    end
    mem_wait = 1'b0;

    // reset asserted mid-LOAD_WAIT clears everything and discards the load
    do_reset();
    apply(mk(8'd0, 8'd0, 1, 1, 8'd7, 1, 0, 0, 0, c_NONE), 100);
    apply(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE), 101);
    apply(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE), 102);
    apply(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_FZ), 103);
    apply(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_FZL), 104);
    @(posedge CLK);
    #2;
    RSTb = 1'b0;
    #1;
    n_vec++;
    if ({stall, bubble, freeze, load_wait} !== 4'b0000 || stall_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_mid_load: flags=%b count=%0d want flags=0000 count=0",
               {stall, bubble, freeze, load_wait}, stall_count);
    end
    @(negedge CLK);
    RSTb = 1'b1;
    model_cnt = 0;
    apply(mk(8'd0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0, c_NONE), 105);
    apply(mk(8'd7, 8'd0, 1, 0, 8'd0, 0, 0, 0, 0, c_NONE), 106);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_hazard_ctl.md
Name: cpu_hazard_ctl

Overview:
Pipeline interlock controller for the SLURM32 core.
- Tracks destination registers of instructions in flight in pipeline slots 1..DEPTH.
- Compares them against the register A/B selects produced by the decoder for the instruction in slot 0.
- Sequences stalls, bubble insertion and whole-pipe freezes for register hazards, outstanding loads and external memory waits.
- Sits between decode and the pipeline-advance logic of the CPU top level.

Parameters:
REGISTER_BITS, 8, width of register selects/tags
DEPTH, 4, number of tracked in-flight slots (slot DEPTH = writeback)
MEM_SLOT, 3, slot in which loads wait for memory data (1 < MEM_SLOT <= DEPTH)
COUNT_BITS, 16, width of stall cycle counter

Ports:
CLK  input  1  clock
RSTb  input  1  asynchronous active-low reset
regA_sel  input  REGISTER_BITS  source A of slot-0 instruction (from decoder)
regB_sel  input  REGISTER_BITS  source B of slot-0 instruction (from decoder)
issue_valid  input  1  slot 0 holds a real instruction
issue_writes  input  1  slot-0 instruction writes a register
issue_dest  input  REGISTER_BITS  destination register of slot-0 instruction
issue_is_load  input  1  slot-0 instruction is a memory load
load_done  input  1  memory returned load data this cycle
mem_wait  input  1  external memory/bus wait, freezes pipe
flush  input  1  branch taken, discard younger instructions
stall  output  1  hold fetch/decode (slot 0 not consumed)
bubble  output  1  insert NOP into slot 1
freeze  output  1  hold all pipeline slots
load_wait  output  1  state == LOAD_WAIT
stall_count  output  COUNT_BITS  saturating count of cycles with stall=1

Behaviour:
- Reset (RSTb low, async): all slot valid bits 0, tags 0, state IDLE, stall_count 0. Outputs stall = bubble = freeze = load_wait = 0. Reset mid-load returns to IDLE and discards the load.
- Slot entry: {valid, tag, is_load}. Register 0 is never tracked: an issue with dest 0 or issue_writes=0 enters slot 1 with valid=0.
- hazard (combinational): issue_valid and (regA_sel or regB_sel) != 0 and equals the tag of any valid slot 1..DEPTH. No forwarding. The writeback slot still counts, because the register file writes at the end of the cycle.
- State machine:
  - IDLE -> LOAD_WAIT when the valid-or-invalid load entry in MEM_SLOT has is_load=1 and load_done=0.
  - LOAD_WAIT -> IDLE on load_done.
  - A load_done in the same cycle the load reaches MEM_SLOT causes no LOAD_WAIT.
- freeze = mem_wait or (state==LOAD_WAIT and !load_done), or the LOAD_WAIT entry condition.
  - Freeze is combinational, so it is asserted in the very cycle the load sits waiting.
- stall = freeze or hazard. bubble = hazard and !freeze.
- Per cycle, priority freeze > hazard > advance:
  - freeze: no slot shifts.
  - hazard: slots shift 1->2..DEPTH-1->DEPTH, slot DEPTH retires, slot 1 gets an invalid entry.
  - advance: shift as above, slot 1 gets the slot-0 entry (valid = issue_valid & issue_writes & dest!=0).
- flush: at the clock edge, invalidates slots 1..MEM_SLOT-1 after the shift is applied, and suppresses the slot-0 entry that cycle. This applies even during freeze. Slot MEM_SLOT and older, including a waiting load, are untouched.
- stall_count increments by 1 on each cycle with stall=1 and saturates at all-ones.
- Latency: hazard to stall is zero cycles (combinational). A dependent instruction issues DEPTH cycles after its producer entered slot 1 at worst.

Test Plan:
- Reset then issue r5 write, then instruction reading regA=5 -> stall=bubble=1 for exactly 4 cycles (DEPTH=4), issue on 5th; stall_count=4.
- Instruction reading r0 while slot holds tag 0 and dest-0 writes in flight -> stall never asserted.
- Load to r7 issued, load_done held low 3 cycles at MEM_SLOT -> freeze=1 and load_wait=1 for 3 cycles, no slot shifts. load_done=1 -> IDLE next cycle, pipe advances.
- Load reaching MEM_SLOT with load_done=1 same cycle -> load_wait stays 0, no freeze.
- Writes r3 (slot 1) and r4 (slot 3) in flight, flush pulse, then read r3 -> no stall; read r4 -> stall until r4 retires.
- Force stall 65535+ cycles via mem_wait -> stall_count saturates at 0xFFFF. Assert RSTb low mid-LOAD_WAIT -> all outputs 0 immediately.
